// File: rtl/cmp_pipe_flopped.sv
// Squares two operands, XOR-folds each square to WIDTH bits and compares the folded values.
// Latency: IN_STAGES + 2 + OUT_STAGES cycles from accept to out_valid (4 by default).
// Backpressure: a single global stall, in_ready = !out_valid || out_ready; every stage holds when stalled.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand beat handshake (in_a, in_b, in_op, in_signed)
//   out_valid/out_ready  result beat handshake (out_result, out_err)
//   stat_true_cnt        saturating count of true results, only when CMP_STATS_EN is defined
//
// Optional feature macro: CMP_STATS_EN (adds the stat_true_cnt port and counter).
module cmp_pipe_flopped #(
  parameter int WIDTH      = 16,
  parameter int IN_STAGES  = 1,
  parameter int OUT_STAGES = 1,
  parameter int STAT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic             out_err
`ifdef CMP_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_true_cnt
`endif
);

  localparam logic [2:0] OP_LT = 3'd0;
  localparam logic [2:0] OP_LE = 3'd1;
  localparam logic [2:0] OP_GT = 3'd2;
  localparam logic [2:0] OP_GE = 3'd3;
  localparam logic [2:0] OP_EQ = 3'd4;
  localparam logic [2:0] OP_NE = 3'd5;

  // Global advance: the whole pipe moves together or not at all.
  logic adv;

  // Operand stages
  logic [WIDTH-1:0] in_a_q   [IN_STAGES];
  logic [WIDTH-1:0] in_b_q   [IN_STAGES];
  logic [2:0]       in_op_q  [IN_STAGES];
  logic             in_sgn_q [IN_STAGES];
  logic             in_vld_q [IN_STAGES];

  // Square stage
  logic [2*WIDTH-1:0] ext_a, ext_b;
  logic [2*WIDTH-1:0] sq_a_d, sq_b_d;
  logic [2*WIDTH-1:0] sq_a_q, sq_b_q;
  logic [2:0]         sq_op_q;
  logic               sq_sgn_q;
  logic               sq_vld_q;

  // Fold stage
  logic [WIDTH-1:0] fa_d, fb_d;
  logic [WIDTH-1:0] fa_q, fb_q;
  logic [2:0]       fold_op_q;
  logic             fold_sgn_q;
  logic             fold_vld_q;

  // Compare and output stages
  logic lt, eq;
  logic res_d, err_d;
  logic out_res_q [OUT_STAGES];
  logic out_err_q [OUT_STAGES];
  logic out_vld_q [OUT_STAGES];

  assign out_valid  = out_vld_q[OUT_STAGES-1];
  assign out_result = out_res_q[OUT_STAGES-1];
  assign out_err    = out_err_q[OUT_STAGES-1];
  assign adv        = !out_valid || out_ready;
  assign in_ready   = adv;

  // Zero-extend before multiplying so the full 2*WIDTH-bit product is kept.
  assign ext_a  = {{WIDTH{1'b0}}, in_a_q[IN_STAGES-1]};
  assign ext_b  = {{WIDTH{1'b0}}, in_b_q[IN_STAGES-1]};
  assign sq_a_d = ext_a * ext_a;
  assign sq_b_d = ext_b * ext_b;

  assign fa_d = sq_a_q[WIDTH-1:0] ^ sq_a_q[2*WIDTH-1:WIDTH];
  assign fb_d = sq_b_q[WIDTH-1:0] ^ sq_b_q[2*WIDTH-1:WIDTH];

  always_comb begin
    res_d = 1'b0;
    err_d = 1'b0;
    eq    = (fa_q == fb_q);
    lt    = fold_sgn_q ? ($signed(fa_q) < $signed(fb_q)) : (fa_q < fb_q);
    case (fold_op_q)
      OP_LT:   res_d = lt;
      OP_LE:   res_d = lt || eq;
      OP_GT:   res_d = !lt && !eq;
      OP_GE:   res_d = !lt;
      OP_EQ:   res_d = eq;
      OP_NE:   res_d = !eq;
      default: err_d = 1'b1;
    endcase
  end

  // Control path: valids and result flags are reset; a beat presented during rst is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IN_STAGES; i++) in_vld_q[i] <= 1'b0;
      sq_vld_q   <= 1'b0;
      fold_vld_q <= 1'b0;
      for (int i = 0; i < OUT_STAGES; i++) begin
        out_vld_q[i] <= 1'b0;
        out_res_q[i] <= 1'b0;
        out_err_q[i] <= 1'b0;
      end
    end else if (adv) begin
      in_vld_q[0] <= in_valid;
      for (int i = 1; i < IN_STAGES; i++) in_vld_q[i] <= in_vld_q[i-1];
      sq_vld_q   <= in_vld_q[IN_STAGES-1];
      fold_vld_q <= sq_vld_q;
      // Flags are gated by valid so bubbles never carry stale results.
      out_vld_q[0] <= fold_vld_q;
      out_res_q[0] <= res_d && fold_vld_q;
      out_err_q[0] <= err_d && fold_vld_q;
      for (int i = 1; i < OUT_STAGES; i++) begin
        out_vld_q[i] <= out_vld_q[i-1];
        out_res_q[i] <= out_res_q[i-1];
        out_err_q[i] <= out_err_q[i-1];
      end
    end
  end

  // Data path: no reset needed, qualified by the valids above.
  always_ff @(posedge clk) begin
    if (adv) begin
      in_a_q[0]   <= in_a;
      in_b_q[0]   <= in_b;
      in_op_q[0]  <= in_op;
      in_sgn_q[0] <= in_signed;
      for (int i = 1; i < IN_STAGES; i++) begin
        in_a_q[i]   <= in_a_q[i-1];
        in_b_q[i]   <= in_b_q[i-1];
        in_op_q[i]  <= in_op_q[i-1];
        in_sgn_q[i] <= in_sgn_q[i-1];
      end
      sq_a_q     <= sq_a_d;
      sq_b_q     <= sq_b_d;
      sq_op_q    <= in_op_q[IN_STAGES-1];
      sq_sgn_q   <= in_sgn_q[IN_STAGES-1];
      fa_q       <= fa_d;
      fb_q       <= fb_d;
      fold_op_q  <= sq_op_q;
      fold_sgn_q <= sq_sgn_q;
    end
  end

`ifdef CMP_STATS_EN
  logic [STAT_W-1:0] stat_q;
  logic [STAT_W-1:0] stat_d;

  // Reserved-op beats always carry out_result=0, the err term keeps that explicit.
  always_comb begin
    stat_d = stat_q;
    if (out_valid && out_ready && out_result && !out_err && (stat_q != {STAT_W{1'b1}}))
      stat_d = stat_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign stat_true_cnt = stat_q;
`else
  logic [STAT_W-1:0] unused_stat_w;
  assign unused_stat_w = '0;
`endif

endmodule

// File: tb/tb_cmp_pipe_flopped.sv
module tb_cmp_pipe_flopped;

  localparam logic [2:0] OP_LT = 3'd0;
  localparam logic [2:0] OP_LE = 3'd1;
  localparam logic [2:0] OP_GT = 3'd2;
  localparam logic [2:0] OP_GE = 3'd3;
  localparam logic [2:0] OP_EQ = 3'd4;
  localparam logic [2:0] OP_NE = 3'd5;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        sgn;
    logic        res;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  in_op;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic        out_result;
  logic        out_err;
`ifdef CMP_STATS_EN
  logic [1:0]  stat_true_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int n_push = 0;
  int n_out  = 0;
  logic [1:0] exp_q [$];   // {err, result}
  vec_t dir_v [11];
  vec_t stall_v [6];

  always #5 clk = ~clk;

  cmp_pipe_flopped #(
    .WIDTH(16), .IN_STAGES(1), .OUT_STAGES(1), .STAT_W(2)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err)
`ifdef CMP_STATS_EN
    , .stat_true_cnt(stat_true_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the beat is accepted.
  task automatic send(input vec_t v, input bit push);
    int  n;
    bit  acc;
    in_valid  = 1'b1;
    in_a      = v.a;
    in_b      = v.b;
    in_op     = v.op;
    in_signed = v.sgn;
    if (push) begin
      exp_q.push_back({v.err, v.res});
      n_push++;
    end
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 32'(acc), 1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 32'(exp_q.size()), 0);
  endtask

  // Scoreboard: every output handshake must match the oldest expected beat,
  // and a stalled result must already show the head's values.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 0);
      end else if (out_ready) begin
        chk("out_result", 32'(out_result), 32'(exp_q[0][0]));
        chk("out_err", 32'(out_err), 32'(exp_q[0][1]));
        void'(exp_q.pop_front());
        n_out++;
      end else begin
        chk("hold_result", 32'(out_result), 32'(exp_q[0][0]));
        chk("hold_err", 32'(out_err), 32'(exp_q[0][1]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    vec_t v;

    dir_v[0]  = '{16'h0100, 16'h0001, OP_EQ, 1'b0, 1'b1, 1'b0};
    dir_v[1]  = '{16'h0100, 16'h0001, OP_NE, 1'b0, 1'b0, 1'b0};
    dir_v[2]  = '{16'h0100, 16'h0001, OP_EQ, 1'b1, 1'b1, 1'b0};
    dir_v[3]  = '{16'd182,  16'd181,  OP_GT, 1'b0, 1'b1, 1'b0};
    dir_v[4]  = '{16'd182,  16'd181,  OP_GT, 1'b1, 1'b0, 1'b0};
    dir_v[5]  = '{16'd182,  16'd181,  OP_LT, 1'b1, 1'b1, 1'b0};
    dir_v[6]  = '{16'hFFFF, 16'h0000, OP_LT, 1'b0, 1'b0, 1'b0};
    dir_v[7]  = '{16'hFFFF, 16'h0000, OP_LT, 1'b1, 1'b1, 1'b0};
    dir_v[8]  = '{16'hFFFF, 16'hFFFF, OP_LE, 1'b0, 1'b1, 1'b0};
    dir_v[9]  = '{16'd3,    16'd5,    3'd6,  1'b0, 1'b0, 1'b1};
    dir_v[10] = '{16'd182,  16'd181,  3'd7,  1'b1, 1'b0, 1'b1};

    stall_v[0] = '{16'd3, 16'd5, OP_LT, 1'b0, 1'b1, 1'b0};
    stall_v[1] = '{16'd3, 16'd5, OP_GE, 1'b0, 1'b0, 1'b0};
    stall_v[2] = '{16'd7, 16'd7, OP_EQ, 1'b0, 1'b1, 1'b0};
    stall_v[3] = '{16'd5, 16'd2, OP_GT, 1'b0, 1'b1, 1'b0};
    stall_v[4] = '{16'd2, 16'd2, OP_LE, 1'b1, 1'b1, 1'b0};
    stall_v[5] = '{16'd6, 16'd1, OP_NE, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_op = '0; in_signed = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_result", 32'(out_result), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
`ifdef CMP_STATS_EN
    chk("rst_stat", 32'(stat_true_cnt), 0);
`endif
    @(posedge clk); #1;

    // Latency of a single beat, counted including the accept edge
    send(stall_v[0], 1'b1);
    idle();
    lat = 1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
      n++;
    end
    chk("latency", 32'(lat), 4);
    chk("lat_result", 32'(out_result), 1);
    @(posedge clk); #1;
    drain();

    // Directed vectors streamed back-to-back
    for (int i = 0; i < 11; i++) send(dir_v[i], 1'b1);
    idle();
    drain();

    // Mixed-op stream with a 3-cycle downstream stall
    fork
      begin
        for (int i = 0; i < 6; i++) send(stall_v[i], 1'b1);
        idle();
      end
      begin
        for (int k = 0; k < 30; k++) begin
          @(posedge clk); #1;
          if (out_valid) break;
        end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 0);
          chk("stall_out_valid", 32'(out_valid), 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Three beats in flight plus one presented on the rst cycle: all dropped
    for (int i = 3; i < 6; i++) send(dir_v[i], 1'b0);
    v = dir_v[0];
    in_a = v.a; in_b = v.b; in_op = v.op; in_signed = v.sgn;
    in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    chk("drop_out_valid", 32'(out_valid), 0);
    chk("drop_in_ready", 32'(in_ready), 1);
    repeat (10) @(posedge clk);
    #1;
    send(dir_v[3], 1'b1);
    idle();
    drain();

`ifdef CMP_STATS_EN
    begin
      logic [1:0] exp_cnt [5];
      logic [1:0] prev;
      exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
      exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("stat_after_rst", 32'(stat_true_cnt), 0);
      // A reserved-op beat must not count
      send(dir_v[9], 1'b1);
      idle();
      drain();
      chk("stat_reserved", 32'(stat_true_cnt), 0);
      prev = 2'd0;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
        send(stall_v[0], 1'b1);
        idle();
        n = 0;
        while (!out_valid && n < 20) begin
          @(posedge clk); #1;
          n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("stat_stall", 32'(stat_true_cnt), 32'(prev));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stat_cnt", 32'(stat_true_cnt), 32'(exp_cnt[k]));
        prev = exp_cnt[k];
      end
      out_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("stat_rst_clear", 32'(stat_true_cnt), 0);
    end
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("outs_seen", 32'(n_out), 32'(n_push));
    chk("exp_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_pipe_flopped.md
Name: cmp_pipe_flopped

Overview:
- Parametrised successor of the fixed 16-bit flopped less-than test wrapper.
- Registers operand pairs, squares each operand, XOR-folds the square to operand width, then compares the folded values.
- Compare op and signedness are selectable per transaction.
- Full valid/ready flow control with backpressure; it is the standard comparator timing test block in the flopped-design suite.

Parameters:
- WIDTH, 16, operand width in bits (>=2).
- IN_STAGES, 1, input register stages (>=1).
- OUT_STAGES, 1, result register stages after the compare (>=1).
- STAT_W, 16, width of the true-result counter (optional feature only).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  3  compare op: 0 LT, 1 LE, 2 GT, 3 GE, 4 EQ, 5 NE, 6/7 reserved.
- in_signed  in  1  compare folded values as two's complement.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  1  compare result.
- out_err  out  1  reserved op was used.
- stat_true_cnt  out  STAT_W  count of true results (present only with CMP_STATS_EN).

Behaviour:
- Pipeline advance enable: adv = !out_valid || out_ready. in_ready = adv, combinational.
- A beat is accepted when in_valid && in_ready.
- When adv=0, every stage holds its data and valid.
- There are no bubbles-collapse requirements; a global stall is sufficient.
- Stage order:
  - IN_STAGES operand registers carry a, b, op, signed and valid.
  - Square stage registers a*a and b*b as unsigned 2*WIDTH-bit products.
  - Fold stage registers fa = sq_a[WIDTH-1:0] ^ sq_a[2W-1:WIDTH], and fb likewise.
  - Compare is combinational on fa/fb, followed by OUT_STAGES result registers.
- Latency, accept to out_valid with no stall: IN_STAGES + 2 + OUT_STAGES cycles. Default is 4.
- Throughput: one beat per cycle when out_ready is held high.
- Compare rules:
  - in_signed=0: fa and fb are compared as unsigned.
  - in_signed=1: fa and fb are compared as signed WIDTH-bit values.
  - EQ and NE ignore in_signed.
- Reserved op (6/7): out_result=0, out_err=1. For all other ops out_err=0.
- op and signed travel with their beat. Mixed ops in back-to-back beats must not interfere.
- Reset: all stage valids, out_valid, out_result and out_err go to 0 on the cycle rst is sampled high.
  - Data registers need not be reset.
  - in_ready=1 during and after reset, because out_valid=0.
- Reset mid-operation: all in-flight beats are dropped; no result is ever produced for them.
- A beat accepted on the same cycle as rst is dropped.
- out_valid/out_result/out_err must remain stable while out_valid && !out_ready.
- WIDTH arithmetic: the products are full 2*WIDTH bits with no truncation before the fold.

Optional Feature:
- Macro: CMP_STATS_EN.
- Defined:
  - stat_true_cnt increments by 1 on each output handshake (out_valid && out_ready) with out_result=1.
  - It saturates at 2^STAT_W-1 and clears to 0 on rst.
  - Reserved-op beats never count.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan (WIDTH=16, IN_STAGES=1, OUT_STAGES=1):
- a=3, b=5, op=LT, unsigned, out_ready=1 -> fa=9, fb=25; out_valid 4 cycles after accept, out_result=1, out_err=0.
- a=0x0100, b=0x0001, op=EQ -> sq_a=0x10000 gives fa=1, fb=1; out_result=1. Same operands with op=NE -> out_result=0.
- a=182, b=181, op=GT:
  - unsigned -> fa=0x8164, fb=0x7FF9, out_result=1.
  - signed -> out_result=0 (fa is negative).
- Stream 6 back-to-back beats with alternating ops while out_ready is low for 3 cycles mid-stream -> in_ready drops during the stall; no beat is lost or duplicated; results arrive in order and are held stable during the stall.
- op=6 with any operands -> out_result=0, out_err=1. Then rst is pulsed for 1 cycle with 3 beats in flight -> out_valid=0 the next cycle and none of the 3 results ever appears.
- CMP_STATS_EN, STAT_W=2, 5 true results accepted -> stat_true_cnt reads 1, 2, 3, 3, 3 (saturates); it does not increment while out_ready=0; rst -> 0.
